// File: rtl/usb_gpx_edge_capture.sv
// Conditions the asynchronous USB GPX pin: synchronise, deglitch, latch edges, count rises,
// raise a maskable interrupt, and expose state through a 4-word Avalon-MM slave.
module usb_gpx_edge_capture #(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gpx_pin,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        gpx_level
);

    localparam int unsigned CTR_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(FILTER_CYCLES - 1);

    logic               s1_q, s2_q;
    logic               level_q, level_d;
    logic               level_dly_q;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [1:0]         mask_q, mask_d;
    logic [1:0]         edge_q, edge_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        readdata_d;
    logic               rise, fall;
    logic               wr_mask, wr_edge, wr_count;

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:2];

    always_comb begin
        // Counter only advances while the synced pin disagrees with the filtered level.
        ctr_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (ctr_q == CTR_MAX) begin
                level_d = s2_q;
            end else begin
                ctr_d = ctr_q + 1'b1;
            end
        end

        rise     = level_q & ~level_dly_q;
        fall     = ~level_q & level_dly_q;
        wr_mask  = write && (address == 2'd1);
        wr_edge  = write && (address == 2'd2);
        wr_count = write && (address == 2'd3);

        mask_d = wr_mask ? writedata[1:0] : mask_q;
        // New edges are ORed in after the W1C so a coincident set wins.
        edge_d = (edge_q & ~(wr_edge ? writedata[1:0] : 2'b00)) | {fall, rise};

        if (wr_count) begin
            count_d = '0;
        end else if (rise) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = {31'b0, level_q};
            2'd1:    readdata_d = {30'b0, mask_q};
            2'd2:    readdata_d = {30'b0, edge_q};
            default: readdata_d = 32'(count_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            ctr_q       <= '0;
            mask_q      <= 2'b00;
            edge_q      <= 2'b00;
            count_q     <= '0;
            readdata    <= '0;
        end else begin
            s1_q        <= gpx_pin;
            s2_q        <= s1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            ctr_q       <= ctr_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            count_q     <= count_d;
            readdata    <= readdata_d;
        end
    end

    assign irq       = |(edge_q & mask_q);
    assign gpx_level = level_q;

endmodule

// File: tb/tb_usb_gpx_edge_capture.sv
// Scoreboard bench for usb_gpx_edge_capture: stimulus queues expected values, a monitor
// compares them just after the following clock edge.
module tb_usb_gpx_edge_capture;

    localparam int KRd  = 0;
    localparam int KIrq = 1;
    localparam int KLvl = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        gpx_pin;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        gpx_level;

    int          checks = 0;
    int          errors = 0;

    int          kind_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    usb_gpx_edge_capture #(
        .FILTER_CYCLES(4),
        .COUNT_W      (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .gpx_pin  (gpx_pin),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .irq      (irq),
        .gpx_level(gpx_level)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued before an edge is checked 1 time unit after it.
    int          m_kind;
    logic [31:0] m_exp;
    logic [31:0] m_got;
    string       m_name;
    always @(posedge clk) begin
        #1;
        while (kind_q.size() != 0) begin
            m_kind = kind_q.pop_front();
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            case (m_kind)
                KRd:     m_got = readdata;
                KIrq:    m_got = {31'b0, irq};
                default: m_got = {31'b0, gpx_level};
            endcase
            checks++;
            if (m_got !== m_exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_name, m_got, m_exp);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_out(input int kind, input logic [31:0] exp, input string name);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        expect_out(KRd, exp, name);
        tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic pulse();
        gpx_pin = 1'b1;
        repeat (8) tick();
        gpx_pin = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        gpx_pin   = 1'b0;
        address   = 2'd0;
        write     = 1'b0;
        writedata = '0;

        // Reset / defaults
        tick();
        expect_out(KRd, 0, "rd_in_reset0");
        expect_out(KIrq, 0, "irq_in_reset");
        tick();
        address = 2'd3;
        expect_out(KRd, 0, "rd_in_reset3");
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        rd(2'd0, 0, "dflt_data");
        rd(2'd1, 0, "dflt_mask");
        rd(2'd2, 0, "dflt_edge");
        expect_out(KIrq, 0, "dflt_irq");
        expect_out(KLvl, 0, "dflt_level");
        rd(2'd3, 0, "dflt_count");

        // Glitch of 3 cycles is rejected
        gpx_pin = 1'b1;
        repeat (3) tick();
        gpx_pin = 1'b0;
        repeat (10) tick();
        expect_out(KLvl, 0, "glitch_level");
        rd(2'd0, 0, "glitch_data");
        rd(2'd2, 0, "glitch_edge");
        rd(2'd3, 0, "glitch_count");

        // Clean step with rise enabled
        wr(2'd1, 1);
        gpx_pin = 1'b1;
        repeat (4) tick();
        expect_out(KLvl, 0, "step_level_t5");
        tick();
        expect_out(KLvl, 1, "step_level_t6");
        expect_out(KIrq, 0, "step_irq_t6");
        tick();
        expect_out(KIrq, 1, "step_irq_t7");
        tick();
        rd(2'd2, 1, "step_edge");
        rd(2'd3, 1, "step_count");
        rd(2'd0, 1, "step_data");
        expect_out(KIrq, 0, "irq_after_w1c");
        wr(2'd2, 1);
        rd(2'd2, 0, "edge_after_w1c");

        // W1C races a new rise: rise bit set wins, fall bit clears
        gpx_pin = 1'b0;
        repeat (8) tick();
        gpx_pin = 1'b1;
        repeat (6) tick();
        wr(2'd2, 3);
        rd(2'd2, 1, "race_set_wins");
        rd(2'd3, 2, "race_count2");

        // COUNT write races a rise: write wins
        gpx_pin = 1'b0;
        repeat (8) tick();
        gpx_pin = 1'b1;
        repeat (6) tick();
        wr(2'd3, 32'hdead_beef);
        rd(2'd3, 0, "race_count_clr");
        rd(2'd2, 3, "race_edge_both");

        // Counter wrap at COUNT_W=4
        gpx_pin = 1'b0;
        repeat (8) tick();
        wr(2'd3, 0);
        wr(2'd2, 3);
        wr(2'd1, 0);
        rd(2'd3, 0, "wrap_start");
        repeat (15) pulse();
        rd(2'd3, 15, "count_15");
        pulse();
        rd(2'd3, 0, "count_wrap");
        wr(2'd2, 3);
        pulse();
        expect_out(KIrq, 0, "irq_masked");
        rd(2'd3, 1, "count_17");
        rd(2'd2, 3, "edge_17");
        expect_out(KIrq, 1, "irq_fall_mask2");
        wr(2'd1, 2);
        rd(2'd1, 2, "mask_rd");
        expect_out(KIrq, 0, "irq_rise_only");
        wr(2'd2, 2);
        rd(2'd2, 1, "edge_rise_only");

        // Reset mid-filter, then release with the pin high
        gpx_pin = 1'b1;
        repeat (4) tick();
        reset_n = 1'b0;
        address = 2'd3;
        expect_out(KRd, 0, "midrst_rd");
        expect_out(KIrq, 0, "midrst_irq");
        expect_out(KLvl, 0, "midrst_level");
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        expect_out(KLvl, 0, "rel_level_t5");
        tick();
        expect_out(KLvl, 1, "rel_level_t6");
        tick();
        tick();
        rd(2'd2, 1, "rel_edge");
        rd(2'd3, 1, "rel_count");
        expect_out(KIrq, 0, "rel_irq");
        rd(2'd1, 0, "rel_mask");

        tick();
        tick();
        if (kind_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
